serv_timer: RTL and testbench

RISC-V machine timer peripheral that drives `i_timer_irq` of the SERV core.
- Holds a 64-bit free-running `mtime` and a 64-bit `mtimecmp`.
- Both are exposed as four 32-bit registers on a Wishbone classic slave port, which hangs off the core's dbus interconnect.
- Raises a level interrupt while `mtime >= mtimecmp`.

---
 rtl/serv_timer.sv | 125 ++++++++++++
 tb/tb_serv_timer.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/serv_timer.sv
// RISC-V machine timer: 64-bit mtime/mtimecmp on a Wishbone classic slave, level irq while mtime >= mtimecmp.
// Ack and read data 1 cycle after accept; one idle cycle between accepted transactions.
module serv_timer #(
    parameter int DIV = 1
) (
    input  logic        clk,
    input  logic        i_rst_n,
    input  logic [1:0]  i_wb_adr,
    input  logic [31:0] i_wb_dat,
    input  logic [3:0]  i_wb_sel,
    input  logic        i_wb_we,
    input  logic        i_wb_cyc,
    output logic [31:0] o_wb_rdt,
    output logic        o_wb_ack,
    output logic        o_timer_irq
);

    localparam logic [15:0] TICK_AT = 16'(DIV - 1);

    localparam logic [1:0] ADR_MTIME_LO = 2'd0;
    localparam logic [1:0] ADR_MTIME_HI = 2'd1;
    localparam logic [1:0] ADR_CMP_LO   = 2'd2;
    localparam logic [1:0] ADR_CMP_HI   = 2'd3;

    logic [15:0] prescaler;
    logic        tick;
    logic [63:0] mtime;
    logic [63:0] mtimecmp;
    logic [31:0] shadow_hi;

    logic        accept;
    logic        wr;
    logic        rd;
    logic        wr_mtime_lo;
    logic        wr_mtime_hi;
    logic        wr_cmp_lo;
    logic        wr_cmp_hi;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  lanes);
        logic [31:0] result;
        result = old_word;
        for (int i = 0; i < 4; i++) begin
            if (lanes[i]) begin
                result[8*i +: 8] = new_word[8*i +: 8];
            end
        end
        return result;
    endfunction

    assign tick   = (prescaler == TICK_AT);
    // A new request is only taken once the previous ack has retired.
    assign accept = i_wb_cyc && !o_wb_ack;
    assign wr     = accept && i_wb_we;
    assign rd     = accept && !i_wb_we;

    assign wr_mtime_lo = wr && (i_wb_adr == ADR_MTIME_LO);
    assign wr_mtime_hi = wr && (i_wb_adr == ADR_MTIME_HI);
    assign wr_cmp_lo   = wr && (i_wb_adr == ADR_CMP_LO);
    assign wr_cmp_hi   = wr && (i_wb_adr == ADR_CMP_HI);

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            prescaler <= '0;
        end else if (tick) begin
            prescaler <= '0;
        end else begin
            prescaler <= prescaler + 16'd1;
        end
    end

    // A software write to either half takes priority over the tick increment.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mtime <= '0;
        end else if (wr_mtime_lo) begin
            mtime[31:0] <= merge_bytes(mtime[31:0], i_wb_dat, i_wb_sel);
        end else if (wr_mtime_hi) begin
            mtime[63:32] <= merge_bytes(mtime[63:32], i_wb_dat, i_wb_sel);
        end else if (tick) begin
            mtime <= mtime + 64'd1;
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            mtimecmp <= '1;
        end else if (wr_cmp_lo) begin
            mtimecmp[31:0] <= merge_bytes(mtimecmp[31:0], i_wb_dat, i_wb_sel);
        end else if (wr_cmp_hi) begin
            mtimecmp[63:32] <= merge_bytes(mtimecmp[63:32], i_wb_dat, i_wb_sel);
        end
    end

    // Reading the low word snapshots the high word so a lo-then-hi read is coherent.
    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_wb_rdt  <= '0;
            shadow_hi <= '0;
        end else if (rd) begin
            unique case (i_wb_adr)
                ADR_MTIME_LO: begin
                    o_wb_rdt  <= mtime[31:0];
                    shadow_hi <= mtime[63:32];
                end
                ADR_MTIME_HI: o_wb_rdt <= shadow_hi;
                ADR_CMP_LO:   o_wb_rdt <= mtimecmp[31:0];
                ADR_CMP_HI:   o_wb_rdt <= mtimecmp[63:32];
                default:      o_wb_rdt <= o_wb_rdt;
            endcase
        end
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_wb_ack    <= 1'b0;
            o_timer_irq <= 1'b0;
        end else begin
            o_wb_ack    <= accept;
            o_timer_irq <= (mtime >= mtimecmp);
        end
    end

endmodule

// File: tb/tb_serv_timer.sv
// Directed bench for serv_timer: one DIV=1 and one DIV=4 instance share the bus inputs.
module tb_serv_timer;

    logic        clk;
    logic        rst_n;
    logic [1:0]  adr;
    logic [31:0] dat;
    logic [3:0]  sel;
    logic        we;
    logic        cyc;

    logic [31:0] rdt1, rdt4;
    logic        ack1, ack4;
    logic        irq1, irq4;

    logic [31:0] rd1, rd4;
    logic [31:0] a1, a4, b1, b4;

    int checks;
    int passed;

    serv_timer #(.DIV(1)) dut1 (
        .clk(clk), .i_rst_n(rst_n), .i_wb_adr(adr), .i_wb_dat(dat), .i_wb_sel(sel),
        .i_wb_we(we), .i_wb_cyc(cyc), .o_wb_rdt(rdt1), .o_wb_ack(ack1), .o_timer_irq(irq1)
    );

    serv_timer #(.DIV(4)) dut4 (
        .clk(clk), .i_rst_n(rst_n), .i_wb_adr(adr), .i_wb_dat(dat), .i_wb_sel(sel),
        .i_wb_we(we), .i_wb_cyc(cyc), .o_wb_rdt(rdt4), .o_wb_ack(ack4), .o_timer_irq(irq4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    // Starts at a negedge, returns at the negedge after the accept edge with rd1/rd4 captured.
    task automatic xfer(input string tag, input logic w, input logic [1:0] a,
                        input logic [31:0] d, input logic [3:0] s);
        @(negedge clk);
        chk({tag, "_idle"}, ack1, 1'b0);
        cyc = 1'b1; we = w; adr = a; dat = d; sel = s;
        @(posedge clk);
        @(negedge clk);
        chk({tag, "_ack"}, ack1, 1'b1);
        rd1 = rdt1;
        rd4 = rdt4;
        cyc = 1'b0; we = 1'b0;
    endtask

    initial begin
        checks = 0;
        passed = 0;
        rst_n = 1'b0; cyc = 1'b0; we = 1'b0; adr = '0; dat = '0; sel = '0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ack", ack1, 1'b0);
        chk("rst_rdt", rdt1, 32'h0);
        chk("rst_irq", irq1, 1'b0);
        chk("rst_ack4", ack4, 1'b0);
        rst_n = 1'b1;

        // mtimecmp resets to all ones, no irq, DIV=1 counts every cycle
        xfer("rd_cmp_lo", 1'b0, 2'd2, 32'h0, 4'hF);
        chk("cmp_lo_rst", rd1, 32'hFFFF_FFFF);
        chk("cmp_lo_rst4", rd4, 32'hFFFF_FFFF);
        xfer("rd_cmp_hi", 1'b0, 2'd3, 32'h0, 4'hF);
        chk("cmp_hi_rst", rd1, 32'hFFFF_FFFF);
        chk("irq_off", irq1, 1'b0);
        xfer("rd_t0", 1'b0, 2'd0, 32'h0, 4'hF);
        a1 = rd1;
        xfer("rd_t1", 1'b0, 2'd0, 32'h0, 4'hF);
        b1 = rd1;
        chk("mtime_step2", 32'(b1 - a1), 32'd2);
        xfer("rd_t2", 1'b0, 2'd0, 32'h0, 4'hF);
        a1 = rd1;
        repeat (3) @(negedge clk);
        xfer("rd_t3", 1'b0, 2'd0, 32'h0, 4'hF);
        b1 = rd1;
        chk("mtime_step5", 32'(b1 - a1), 32'd5);
        chk("irq_off2", irq1, 1'b0);

        // DIV=4: 8 cycles apart gives 2 increments whatever the prescaler phase
        xfer("wr_lo0", 1'b1, 2'd0, 32'h0, 4'hF);
        xfer("rd_d0", 1'b0, 2'd0, 32'h0, 4'hF);
        a1 = rd1; a4 = rd4;
        repeat (6) @(negedge clk);
        xfer("rd_d1", 1'b0, 2'd0, 32'h0, 4'hF);
        b1 = rd1; b4 = rd4;
        chk("div4_step", 32'(b4 - a4), 32'd2);
        chk("div1_step", 32'(b1 - a1), 32'd8);

        // Interrupt: mtime is 4 after the mtimecmp lo write, reaches 10 six edges later
        xfer("wr_thi", 1'b1, 2'd1, 32'h0, 4'hF);
        xfer("wr_tlo", 1'b1, 2'd0, 32'h0, 4'hF);
        xfer("wr_chi", 1'b1, 2'd3, 32'h0, 4'hF);
        xfer("wr_clo", 1'b1, 2'd2, 32'd10, 4'hF);
        chk("irq_low0", irq1, 1'b0);
        repeat (6) @(negedge clk);
        chk("irq_early", irq1, 1'b0);
        @(negedge clk);
        chk("irq_rise", irq1, 1'b1);
        xfer("rd_cmp10", 1'b0, 2'd2, 32'h0, 4'hF);
        chk("cmp_lo10", rd1, 32'd10);
        chk("irq_after_rd", irq1, 1'b1);
        xfer("wr_c1000", 1'b1, 2'd2, 32'd1000, 4'hF);
        chk("irq_hold", irq1, 1'b1);
        @(negedge clk);
        chk("irq_fall", irq1, 1'b0);

        // Byte lanes; writes leave o_wb_rdt alone; sel ignored on reads
        xfer("wr_c_full", 1'b1, 2'd2, 32'h1234_5678, 4'hF);
        xfer("wr_c_lanes", 1'b1, 2'd2, 32'hAABB_CCDD, 4'b0101);
        xfer("rd_c_lanes", 1'b0, 2'd2, 32'h0, 4'h0);
        chk("byte_lanes", rd1, 32'h12BB_56DD);
        xfer("wr_chi0", 1'b1, 2'd3, 32'h0, 4'hF);
        chk("rdt_hold_wr", rdt1, 32'h12BB_56DD);

        // Write beats the tick: one increment between the write and the read
        xfer("wr_pri", 1'b1, 2'd0, 32'h0000_1000, 4'hF);
        xfer("rd_pri", 1'b0, 2'd0, 32'h0, 4'hF);
        chk("write_prio", rd1, 32'h0000_1001);

        // Shadow coherence across the carry into mtime hi
        xfer("wr_shi", 1'b1, 2'd1, 32'h0, 4'hF);
        xfer("wr_slo", 1'b1, 2'd0, 32'hFFFF_FFFE, 4'hF);
        xfer("rd_slo", 1'b0, 2'd0, 32'h0, 4'hF);
        chk("shadow_lo", rd1, 32'hFFFF_FFFF);
        repeat (5) @(negedge clk);
        xfer("rd_shi", 1'b0, 2'd1, 32'h0, 4'hF);
        chk("shadow_hi", rd1, 32'h0);
        xfer("rd_slo2", 1'b0, 2'd0, 32'h0, 4'hF);
        chk("carry_lo", rd1, 32'd8);
        xfer("rd_shi2", 1'b0, 2'd1, 32'h0, 4'hF);
        chk("carry_hi", rd1, 32'd1);

        // Reset while a write to mtimecmp lo is being acked
        @(negedge clk);
        cyc = 1'b1; we = 1'b1; adr = 2'd2; dat = 32'h0; sel = 4'hF;
        @(posedge clk);
        @(negedge clk);
        chk("mid_ack", ack1, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("mid_ack_drop", ack1, 1'b0);
        chk("mid_ack_drop4", ack4, 1'b0);
        cyc = 1'b0; we = 1'b0;
        @(negedge clk);
        chk("mid_irq", irq1, 1'b0);
        chk("mid_rdt", rdt1, 32'h0);
        rst_n = 1'b1;
        xfer("rd_post_t", 1'b0, 2'd0, 32'h0, 4'hF);
        chk("post_mtime1", rd1, 32'd1);
        chk("post_mtime4", rd4, 32'd0);
        xfer("rd_post_clo", 1'b0, 2'd2, 32'h0, 4'hF);
        chk("post_cmp_lo", rd1, 32'hFFFF_FFFF);
        xfer("rd_post_chi", 1'b0, 2'd3, 32'h0, 4'hF);
        chk("post_cmp_hi", rd1, 32'hFFFF_FFFF);
        chk("post_irq", irq1, 1'b0);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
